// File: rtl/iterative_multiplier.sv
// iterative_multiplier: shift-add MUL / MLA / UMULL unit, W+1 cycles per op.
// Ports: clk, i_rst_n, start + SrcA/SrcB/Acc operands and mode bits in;
//        busy/done handshake, 2W-bit result and N/Z flags out.
module iterative_multiplier #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [W-1:0] i_SrcA,
  input  logic [W-1:0] i_SrcB,
  input  logic [W-1:0] i_Acc,
  input  logic         i_accumulate,
  input  logic         i_long,
  input  logic         i_S,
  output logic         o_busy,
  output logic         o_done,
  output logic [W-1:0] o_result,
  output logic [W-1:0] o_result_hi,
  output logic         o_N,
  output logic         o_Z
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    ACC,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [2*W-1:0] p;
  logic [2*W-1:0] p_acc;
  logic [W-1:0]   a_q;
  logic [W-1:0]   acc_q;
  logic           accum_q;
  logic           long_q;
  logic           s_q;
  logic [CW-1:0]  cnt;
  logic           n_q;
  logic           z_q;
  logic           accept;
  logic           last;
  logic [W:0]     sum;

  assign accept = i_start &&
                  (state == IDLE || state == DONE);
  assign last   = (cnt == CW'(W - 1));

  // Upper half plus multiplicand when the current
  // multiplier bit (P[0]) is set; carry kept in bit W.
  assign sum = {1'b0, p[2*W-1:W]}
             + ({1'b0, a_q} & {(W+1){p[0]}});

  // Accumulate wraps modulo 2^(2W).
  assign p_acc = accum_q
               ? p + {{W{1'b0}}, acc_q}
               : p;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (i_start) state_nx = RUN;
      end
      RUN: begin
        if (last) state_nx = ACC;
      end
      ACC: begin
        state_nx = DONE;
      end
      DONE: begin
        if (i_start) state_nx = RUN;
        else         state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      p       <= '0;
      a_q     <= '0;
      acc_q   <= '0;
      accum_q <= 1'b0;
      long_q  <= 1'b0;
      s_q     <= 1'b0;
      cnt     <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
    end else if (accept) begin
      p       <= {{W{1'b0}}, i_SrcB};
      a_q     <= i_SrcA;
      acc_q   <= i_Acc;
      accum_q <= i_accumulate;
      long_q  <= i_long;
      s_q     <= i_S;
      cnt     <= '0;
    end else begin
      unique case (state)
        RUN: begin
          p   <= {sum, p[W-1:1]};
          cnt <= cnt + 1'b1;
        end
        ACC: begin
          p <= p_acc;
          // Flags land together with the final
          // product on the edge into DONE.
          if (s_q) begin
            if (long_q) begin
              n_q <= p_acc[2*W-1];
              z_q <= (p_acc == '0);
            end else begin
              n_q <= p_acc[W-1];
              z_q <= (p_acc[W-1:0] == '0);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_busy      = (state == RUN) ||
                       (state == ACC);
  assign o_done      = (state == DONE);
  assign o_result    = p[W-1:0];
  assign o_result_hi = p[2*W-1:W];
  assign o_N         = n_q;
  assign o_Z         = z_q;

endmodule

// File: tb/tb_iterative_multiplier.sv
// tb_iterative_multiplier: directed checks of iterative_multiplier
// against a product/countdown reference model and literal results.
module tb_iterative_multiplier;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         i_rst_n = 1'b1;
  logic         i_start = 1'b0;
  logic [W-1:0] i_SrcA = '0;
  logic [W-1:0] i_SrcB = '0;
  logic [W-1:0] i_Acc = '0;
  logic         i_accumulate = 1'b0;
  logic         i_long = 1'b0;
  logic         i_S = 1'b0;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_result;
  logic [W-1:0] o_result_hi;
  logic         o_N;
  logic         o_Z;

  int n_chk  = 0;
  int n_fail = 0;
  int n_done = 0;

  always #5 clk = ~clk;

  iterative_multiplier #(.W(W)) dut (
    .clk          (clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_SrcA       (i_SrcA),
    .i_SrcB       (i_SrcB),
    .i_Acc        (i_Acc),
    .i_accumulate (i_accumulate),
    .i_long       (i_long),
    .i_S          (i_S),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_result     (o_result),
    .o_result_hi  (o_result_hi),
    .o_N          (o_N),
    .o_Z          (o_Z)
  );

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference: an accepted op finishes W+1 edges later
  // with A*B(+Acc) mod 2^64; flags from that value.
  int          left = 0;
  logic [63:0] pend = '0;
  logic [63:0] m_res = '0;
  logic        pend_s = 1'b0;
  logic        pend_l = 1'b0;
  logic        m_done = 1'b0;
  logic        m_n = 1'b0;
  logic        m_z = 1'b0;

  always @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      left   <= 0;
      m_res  <= '0;
      m_done <= 1'b0;
      m_n    <= 1'b0;
      m_z    <= 1'b0;
    end else if (left != 0) begin
      left <= left - 1;
      if (left == 1) begin
        m_done <= 1'b1;
        m_res  <= pend;
        if (pend_s) begin
          m_n <= pend_l ? pend[63] : pend[31];
          m_z <= pend_l ? (pend == 64'd0)
                        : (pend[31:0] == 32'd0);
        end
      end
    end else begin
      m_done <= 1'b0;
      if (i_start) begin
        left   <= W + 1;
        pend   <= 64'(i_SrcA) * 64'(i_SrcB)
                + (i_accumulate ? 64'(i_Acc) : 64'd0);
        pend_s <= i_S;
        pend_l <= i_long;
      end
    end
  end

  always @(negedge clk) begin
    check("busy", 64'(o_busy), 64'(left != 0));
    check("done", 64'(o_done), 64'(m_done));
    check("flag_n", 64'(o_N), 64'(m_n));
    check("flag_z", 64'(o_Z), 64'(m_z));
    if (left == 0) begin
      check("res_lo", 64'(o_result), 64'(m_res[31:0]));
      check("res_hi", 64'(o_result_hi), 64'(m_res[63:32]));
    end
    if (o_done) n_done++;
  end

  task automatic start_op(input logic [31:0] a,
                          input logic [31:0] b,
                          input logic [31:0] acc,
                          input logic accm,
                          input logic lng,
                          input logic s);
    i_SrcA       = a;
    i_SrcB       = b;
    i_Acc        = acc;
    i_accumulate = accm;
    i_long       = lng;
    i_S          = s;
    i_start      = 1'b1;
    @(posedge clk);
    #1;
    i_start      = 1'b0;
    i_SrcA       = 32'hDEAD_BEEF;
    i_SrcB       = 32'h1234_5678;
    i_Acc        = 32'hCAFE_F00D;
    i_accumulate = ~accm;
    i_long       = ~lng;
    i_S          = ~s;
  endtask

  task automatic wait_done(input int inj,
                           output int edges,
                           output int busy);
    edges = 0;
    busy  = 0;
    while (edges < 100) begin
      if (o_busy) busy++;
      if (edges == inj) begin
        i_start = 1'b1;
        i_SrcA  = 32'd9;
        i_SrcB  = 32'd9;
      end
      if (edges == inj + 1) i_start = 1'b0;
      @(posedge clk);
      #1;
      edges++;
      if (o_done) break;
    end
    check("done_seen", 64'(o_done), 64'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm,
                         input logic [31:0] hi,
                         input logic [31:0] lo,
                         input logic n,
                         input logic z);
    check({nm, "_hi"}, 64'(o_result_hi), 64'(hi));
    check({nm, "_lo"}, 64'(o_result), 64'(lo));
    check({nm, "_N"}, 64'(o_N), 64'(n));
    check({nm, "_Z"}, 64'(o_Z), 64'(z));
  endtask

  initial begin
    int e;
    int b;
    int d0;

    #1 i_rst_n = 1'b0;
    #3;
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_done", 64'(o_done), 64'd0);
    chk_out("rst", 32'd0, 32'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1 i_rst_n = 1'b1;
    idle(2);

    d0 = n_done;
    start_op(32'd5, 32'd7, 32'd0, 1'b0, 1'b0, 1'b0);
    wait_done(-1, e, b);
    check("mul_edges", 64'(e), 64'd33);
    check("mul_busy", 64'(b), 64'd33);
    chk_out("mul", 32'd0, 32'd35, 1'b0, 1'b0);
    idle(3);
    check("mul_pulses", 64'(n_done - d0), 64'd1);

    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,
             1'b0, 1'b1, 1'b0);
    wait_done(-1, e, b);
    chk_out("lmax", 32'hFFFF_FFFE, 32'h0000_0001,
            1'b0, 1'b0);
    idle(2);

    start_op(32'd15, 32'd5, 32'd10, 1'b1, 1'b0, 1'b1);
    wait_done(-1, e, b);
    chk_out("mla", 32'd0, 32'd85, 1'b0, 1'b0);
    idle(2);

    start_op(32'd0, 32'd9, 32'd0, 1'b1, 1'b0, 1'b1);
    wait_done(-1, e, b);
    chk_out("zero", 32'd0, 32'd0, 1'b0, 1'b1);
    idle(2);

    start_op(32'h8000_0000, 32'd1, 32'h8000_0000,
             1'b1, 1'b1, 1'b1);
    wait_done(-1, e, b);
    chk_out("wrapl", 32'd1, 32'd0, 1'b0, 1'b0);
    idle(2);

    start_op(32'h8000_0000, 32'd1, 32'h8000_0000,
             1'b1, 1'b0, 1'b1);
    wait_done(-1, e, b);
    chk_out("wraps", 32'd1, 32'd0, 1'b0, 1'b1);
    idle(2);

    d0 = n_done;
    start_op(32'd5, 32'd7, 32'd0, 1'b0, 1'b0, 1'b0);
    wait_done(10, e, b);
    check("ign_edges", 64'(e), 64'd33);
    chk_out("ign", 32'd0, 32'd35, 1'b0, 1'b1);
    idle(40);
    check("ign_pulses", 64'(n_done - d0), 64'd1);

    start_op(32'd5, 32'd7, 32'd0, 1'b0, 1'b0, 1'b0);
    idle(12);
    #2 i_rst_n = 1'b0;
    #1;
    check("mid_busy", 64'(o_busy), 64'd0);
    check("mid_done", 64'(o_done), 64'd0);
    chk_out("mid", 32'd0, 32'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1 i_rst_n = 1'b1;
    d0 = n_done;
    idle(40);
    check("abort_pulses", 64'(n_done - d0), 64'd0);

    start_op(32'd3, 32'd4, 32'd0, 1'b0, 1'b0, 1'b0);
    wait_done(-1, e, b);
    check("b2b1_edges", 64'(e), 64'd33);
    chk_out("b2b1", 32'd0, 32'd12, 1'b0, 1'b0);
    start_op(32'd6, 32'd6, 32'd0, 1'b0, 1'b0, 1'b0);
    check("b2b_busy", 64'(o_busy), 64'd1);
    wait_done(-1, e, b);
    check("b2b2_edges", 64'(e), 64'd33);
    chk_out("b2b2", 32'd0, 32'd36, 1'b0, 1'b0);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
